counter_capture_fifo: RTL and testbench

- Downstream consumer of the 8-bit free-running ripple counter's `out_value`.
- Timestamps asynchronous external events by sampling the counter value when an event's rising edge is detected.
- Buffers the samples in a small FIFO and presents them through a valid/ready interface to the readout logic.
- Reports a sticky overflow flag when an event arrives while the FIFO is full.

---
 rtl/counter_pkg.sv | 9 +
 rtl/sync_edge_detect.sv | 32 +++
 rtl/counter_capture_fifo.sv | 92 +++++++++
 tb/tb_counter_capture_fifo.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants for the counter subsystem: the counter width and the
// default geometry of the capture FIFO that timestamps events against it.
package counter_pkg;

    localparam int COUNT_WIDTH         = 8;
    localparam int CAPTURE_DEPTH       = 4;
    localparam int CAPTURE_SYNC_STAGES = 2;

endpackage : counter_pkg

// File: rtl/sync_edge_detect.sv
// Synchronises an asynchronous strobe and emits a registered one-cycle pulse
// on each rising edge it resolves. Reused for all async inputs of the subsystem.
module sync_edge_detect
    import counter_pkg::*;
#(
    parameter int SYNC_STAGES = CAPTURE_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Flops reset high so a strobe held high across reset release looks like
    // "already seen" and never produces a pulse until it drops and rises again.
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
            pulse  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
            pulse  <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

endmodule : sync_edge_detect

// File: rtl/counter_capture_fifo.sv
// Timestamps rising edges of an async event with the current counter value
// and queues the samples for readout over a valid/ready interface.
module counter_capture_fifo
    import counter_pkg::*;
#(
    parameter int WIDTH       = COUNT_WIDTH,
    parameter int DEPTH       = CAPTURE_DEPTH,
    parameter int SYNC_STAGES = CAPTURE_SYNC_STAGES
) (
    input  logic                     in_clock,
    input  logic                     in_reset,
    input  logic [WIDTH-1:0]         in_count,
    input  logic                     in_event,
    input  logic                     in_clear,
    input  logic                     in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   out_level,
    output logic                     out_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW-1:0]    wr_next, rd_next;
    logic [WIDTH-1:0] head_next;
    logic             capture, full, push, pop, drop;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_event_sync (
        .clk      (in_clock),
        .rst_n    (in_reset),
        .async_in (in_event),
        .pulse    (capture)
    );

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop  = out_valid & in_ready;
    assign push = capture & (~full | pop);
    assign drop = capture & full & ~pop;

    // NOTE: every always_comb output gets a value on every path, so no latches.
    always_comb begin
        wr_next   = wr_ptr + PW'(push);
        rd_next   = rd_ptr + PW'(pop);
        head_next = mem[rd_next[AW-1:0]];
        // A push landing in the next head slot is not in mem yet: forward it.
        if (push && (wr_ptr[AW-1:0] == rd_next[AW-1:0])) begin
            head_next = in_count;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are live.
    always_ff @(posedge in_clock) begin
        if (push && !in_clear) begin
            mem[wr_ptr[AW-1:0]] <= in_count;
        end
    end

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_level    <= '0;
            out_overflow <= 1'b0;
        end else if (in_clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            out_valid    <= 1'b0;
            out_level    <= '0;
            out_overflow <= 1'b0;
        end else begin
            wr_ptr    <= wr_next;
            rd_ptr    <= rd_next;
            out_level <= wr_next - rd_next;
            out_valid <= (wr_next != rd_next);
            if (wr_next != rd_next) begin
                out_data <= head_next;
            end
            if (drop) begin
                out_overflow <= 1'b1;
            end
        end
    end

endmodule : counter_capture_fifo

// File: tb/tb_counter_capture_fifo.sv
// Directed bench for counter_capture_fifo: in_count follows a bench cycle
// index, so an event raised in cycle c captures the value c+3.
module tb_counter_capture_fifo;

    logic       in_clock = 1'b0;
    logic       in_reset;
    logic [7:0] in_count;
    logic       in_event;
    logic       in_clear;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [2:0] out_level;
    logic       out_overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int c0;
    int q[$];

    counter_capture_fifo dut (
        .in_clock     (in_clock),
        .in_reset     (in_reset),
        .in_count     (in_count),
        .in_event     (in_event),
        .in_clear     (in_clear),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_level    (out_level),
        .out_overflow (out_overflow)
    );

    always #5 in_clock = ~in_clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge in_clock);
        #1;
        cyc++;
        in_count = 8'(cyc);
    endtask

    task automatic set_cycle(input int v);
        cyc      = v;
        in_count = 8'(v);
    endtask

    // Raise in_event so that the capture pulse lands in cycle v (sample = v).
    task automatic event_at(input int v);
        while (cyc < v - 3) tick();
        in_event = 1'b1;
        tick();
        in_event = 1'b0;
    endtask

    task automatic wait_until(input int v);
        while (cyc < v) tick();
    endtask

    initial begin
        in_reset = 1'b0;
        in_count = 8'd0;
        in_event = 1'b0;
        in_clear = 1'b0;
        in_ready = 1'b0;
        #1;
        check("reset_valid", out_valid, 0);
        check("reset_data", out_data, 0);
        check("reset_level", out_level, 0);
        check("reset_ovf", out_overflow, 0);
        repeat (3) tick();
        in_reset = 1'b1;
        repeat (4) tick();

        // Single capture with a 4-cycle-wide event and in_ready held high.
        in_ready = 1'b1;
        c0 = cyc;
        in_event = 1'b1;
        tick();
        check("single_early", out_valid, 0);
        tick();
        tick();
        check("single_pulse_cycle", out_valid, 0);
        tick();
        in_event = 1'b0;
        check("single_valid", out_valid, 1);
        check("single_data", out_data, 32'(8'(c0 + 3)));
        check("single_level", out_level, 1);
        tick();
        check("single_valid_drop", out_valid, 0);
        check("single_level_zero", out_level, 0);
        repeat (6) tick();
        check("single_no_second", out_level, 0);

        // Fill to four entries, fifth event overflows.
        in_ready = 1'b0;
        set_cycle(0);
        event_at(10);
        event_at(20);
        event_at(30);
        event_at(40);
        event_at(50);
        check("fill_level_4", out_level, 4);
        check("fill_no_ovf_yet", out_overflow, 0);
        wait_until(52);
        check("fill_level_sat", out_level, 4);
        check("fill_ovf", out_overflow, 1);
        in_ready = 1'b1;
        check("drain_0", out_data, 10);
        tick();
        check("drain_1", out_data, 20);
        tick();
        check("drain_2", out_data, 30);
        tick();
        check("drain_3", out_data, 40);
        check("drain_3_valid", out_valid, 1);
        tick();
        check("drain_empty", out_valid, 0);
        check("drain_level", out_level, 0);
        check("drain_ovf_sticky", out_overflow, 1);
        in_ready = 1'b0;
        in_clear = 1'b1;
        tick();
        in_clear = 1'b0;
        check("clear_ovf", out_overflow, 0);

        // Full FIFO, pop coincides with the capture pulse.
        set_cycle(0);
        event_at(10);
        event_at(20);
        event_at(30);
        event_at(40);
        event_at(60);
        wait_until(60);
        check("pp_full_level", out_level, 4);
        in_ready = 1'b1;
        check("pp_head", out_data, 10);
        tick();
        in_ready = 1'b0;
        check("pp_level", out_level, 4);
        check("pp_ovf", out_overflow, 0);
        check("pp_head_next", out_data, 20);
        in_ready = 1'b1;
        tick();
        check("pp_drain_30", out_data, 30);
        tick();
        check("pp_drain_40", out_data, 40);
        tick();
        check("pp_drain_60", out_data, 60);
        tick();
        check("pp_empty", out_valid, 0);
        in_ready = 1'b0;

        // Backpressure: ready toggles every two cycles with two entries queued.
        set_cycle(0);
        event_at(10);
        event_at(20);
        wait_until(22);
        check("bp_level", out_level, 2);
        q = {10, 20};
        for (int i = 0; i < 10; i++) begin
            in_ready = ((i / 2) % 2) == 1;
            if (q.size() > 0) begin
                check("bp_valid", out_valid, 1);
                check("bp_data", out_data, q[0]);
                if (in_ready) void'(q.pop_front());
            end else begin
                check("bp_idle", out_valid, 0);
            end
            tick();
        end
        in_ready = 1'b0;

        // Clear with three entries, overflow set, and a concurrent capture.
        set_cycle(0);
        event_at(10);
        event_at(20);
        event_at(30);
        event_at(40);
        event_at(50);
        wait_until(51);
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        check("clr_pre_level", out_level, 3);
        check("clr_pre_ovf", out_overflow, 1);
        event_at(60);
        wait_until(60);
        in_clear = 1'b1;
        tick();
        in_clear = 1'b0;
        check("clr_level", out_level, 0);
        check("clr_valid", out_valid, 0);
        check("clr_ovf", out_overflow, 0);
        repeat (3) tick();
        check("clr_discarded", out_level, 0);

        // Event held high through reset release never captures.
        in_event = 1'b1;
        in_reset = 1'b0;
        tick();
        tick();
        in_reset = 1'b1;
        repeat (6) tick();
        check("rst_hold_level", out_level, 0);
        check("rst_hold_valid", out_valid, 0);
        in_event = 1'b0;
        repeat (4) tick();
        check("rst_hold_after", out_level, 0);

        // Reset mid-drain with two entries.
        set_cycle(0);
        event_at(10);
        event_at(20);
        wait_until(21);
        in_ready = 1'b1;
        check("mid_head", out_data, 10);
        tick();
        check("mid_second", out_data, 20);
        in_reset = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_level", out_level, 0);
        check("mid_rst_ovf", out_overflow, 0);
        tick();
        tick();
        in_reset = 1'b1;
        repeat (6) tick();
        check("mid_post_valid", out_valid, 0);
        check("mid_post_level", out_level, 0);
        check("mid_post_data", out_data, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_counter_capture_fifo
